// File: rtl/clk_meas_pkg.sv
// Shared definitions for the clock period meter: FSM state encoding and the
// default width / timeout constants also used by the divider testbench.
package clk_meas_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2
   } meas_state_t;

   localparam int unsigned DEF_N           = 32;
   localparam logic [31:0] DEF_MAX_COUNT   = 32'd50_000_000;
   localparam int unsigned DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// Brings an asynchronous level into the in_clk domain through a flop chain
// and flags the cycle in which the synchronized level first reads high.
module sync_edge_detect #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic in_clk,
   input  logic reset_n,
   input  logic async_in,
   output logic sync_out,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   s_dly_q, s_dly_d;

   // Next values: shift the raw input in, keep one extra delayed copy
   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], async_in};
      s_dly_d = sync_q[SYNC_STAGES-1];
   end

   // Synchronizer chain plus the delayed copy used for edge detection
   always_ff @(posedge in_clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q  <= '0;
         s_dly_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         s_dly_q <= s_dly_d;
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];
   assign rise     = sync_out & ~s_dly_q;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of an asynchronous square wave in in_clk
// cycles. The high-time counter exists only when DUTY_MEAS_EN is defined;
// otherwise high_count reads 0 and everything else behaves the same.
module clock_period_meter
   import clk_meas_pkg::*;
#(
   parameter int unsigned  N           = DEF_N,
   parameter logic [N-1:0] MAX_COUNT   = N'(DEF_MAX_COUNT),
   parameter int unsigned  SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic         in_clk,
   input  logic         reset_n,
   input  logic         on_off,
   input  logic         meas_in,
   output logic [N-1:0] period_count,
   output logic [N-1:0] high_count,
   output logic         valid,
   output logic         no_signal
);

   logic        sync_s;
   logic        rise;
   logic        ctr_clear;
   logic        ctr_load;
   logic        capture;

   meas_state_t  state_q, state_d;
   logic [N-1:0] cnt_q, cnt_d;
   logic [N-1:0] period_q, period_d;
   logic         valid_q, valid_d;
   logic         no_signal_q, no_signal_d;

   sync_edge_detect #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .in_clk   (in_clk),
      .reset_n  (reset_n),
      .async_in (meas_in),
      .sync_out (sync_s),
      .rise     (rise)
   );

   // FSM next state, period counter and result capture; an edge always wins
   // over a timeout landing in the same cycle
   always_comb begin
      state_d     = state_q;
      period_d    = period_q;
      valid_d     = 1'b0;
      no_signal_d = no_signal_q;
      ctr_clear   = 1'b0;
      ctr_load    = 1'b0;
      capture     = 1'b0;
      if (!on_off) begin
         state_d     = IDLE;
         ctr_clear   = 1'b1;
         period_d    = '0;
         no_signal_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d   = ARM;
               ctr_clear = 1'b1;
            end
            ARM, MEASURE: begin
               if (rise) begin
                  ctr_load    = 1'b1;
                  no_signal_d = 1'b0;
                  state_d     = MEASURE;
                  // In ARM the window before the first edge is partial and dropped
                  if (state_q == MEASURE) begin
                     capture  = 1'b1;
                     period_d = cnt_q;
                     valid_d  = 1'b1;
                  end
               end else if (cnt_q == MAX_COUNT) begin
                  ctr_clear   = 1'b1;
                  no_signal_d = 1'b1;
                  state_d     = ARM;
               end
            end
            default: begin
               state_d   = IDLE;
               ctr_clear = 1'b1;
            end
         endcase
      end
      if (ctr_clear) begin
         cnt_d = '0;
      end else if (ctr_load) begin
         cnt_d = {{(N-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q + {{(N-1){1'b0}}, 1'b1};
      end
   end

   // State, period counter and registered outputs
   always_ff @(posedge in_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         period_q    <= '0;
         valid_q     <= 1'b0;
         no_signal_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         period_q    <= period_d;
         valid_q     <= valid_d;
         no_signal_q <= no_signal_d;
      end
   end

`ifdef DUTY_MEAS_EN
   logic [N-1:0] hcnt_q, hcnt_d;
   logic [N-1:0] high_q, high_d;

   // High-time counter shares clear/load with cnt and adds the synced level
   always_comb begin
      hcnt_d = hcnt_q + {{(N-1){1'b0}}, sync_s};
      high_d = high_q;
      if (ctr_clear) begin
         hcnt_d = '0;
      end else if (ctr_load) begin
         hcnt_d = {{(N-1){1'b0}}, 1'b1};
      end
      if (!on_off) begin
         high_d = '0;
      end else if (capture) begin
         high_d = hcnt_q;
      end
   end

   // High-time counter and its result register
   always_ff @(posedge in_clk or negedge reset_n) begin
      if (!reset_n) begin
         hcnt_q <= '0;
         high_q <= '0;
      end else begin
         hcnt_q <= hcnt_d;
         high_q <= high_d;
      end
   end

   assign high_count = high_q;
`else
   // Synced level and capture strobe only feed the duty measurement
   logic unused_duty;
   assign unused_duty = sync_s ^ capture;
   assign high_count  = '0;
`endif

   assign period_count = period_q;
   assign valid        = valid_q;
   assign no_signal    = no_signal_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Self-checking bench for clock_period_meter: table of square waves plus
// hand-written timeout, on_off drop and asynchronous reset sequences.
module tb_clock_period_meter;
   import clk_meas_pkg::*;

   localparam int N    = 32;
   localparam int MAXC = 1100;

   logic         in_clk  = 1'b0;
   logic         reset_n = 1'b0;
   logic         on_off  = 1'b0;
   logic         meas_in = 1'b0;
   logic [N-1:0] period_count;
   logic [N-1:0] high_count;
   logic         valid;
   logic         no_signal;

   int checks = 0;
   int errors = 0;

   clock_period_meter #(
      .N           (N),
      .MAX_COUNT   (32'(MAXC)),
      .SYNC_STAGES (2)
   ) dut (
      .in_clk       (in_clk),
      .reset_n      (reset_n),
      .on_off       (on_off),
      .meas_in      (meas_in),
      .period_count (period_count),
      .high_count   (high_count),
      .valid        (valid),
      .no_signal    (no_signal)
   );

   always #5 in_clk = ~in_clk;

   // Divider-style wave generator: period gen_f, last gen_h phases high
   int   gen_mode  = 0;
   int   gen_f     = 4;
   int   gen_h     = 2;
   int   gen_phase = 0;
   int   rise_cnt  = 0;
   logic gen_nxt;

   initial begin
      forever begin
         @(posedge in_clk);
         #2;
         if (gen_mode == 1) begin
            gen_nxt   = (gen_phase >= gen_f - gen_h);
            gen_phase = (gen_phase + 1) % gen_f;
         end else begin
            gen_nxt = 1'b0;
         end
         if (gen_nxt && !meas_in) rise_cnt++;
         meas_in = gen_nxt;
      end
   end

   function automatic int hx(input int h);
`ifdef DUTY_MEAS_EN
      return h;
`else
      return 0;
`endif
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // valid must never be high on two consecutive cycles
   logic prev_valid = 1'b0;
   always @(negedge in_clk) begin
      if (valid) begin
         checks++;
         if (prev_valid) begin
            errors++;
            $display("FAIL valid_back_to_back: got 1 expected 0 at %0t", $time);
         end
      end
      prev_valid = valid;
   end

   task automatic wait_valid(input int budget, output int cycles, output bit ok);
      cycles = 0;
      ok     = 1'b0;
      while (cycles < budget) begin
         @(negedge in_clk);
         cycles++;
         if (valid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_meas_rise(input int budget);
      int r0;
      int c;
      r0 = rise_cnt;
      c  = 0;
      while (rise_cnt == r0 && c < budget) begin
         @(negedge in_clk);
         c++;
      end
      chk("meas_rise_seen", (rise_cnt != r0), 1);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_period"}, period_count, 0);
      chk({tag, "_high"}, high_count, 0);
      chk({tag, "_valid"}, valid, 0);
      chk({tag, "_no_signal"}, no_signal, 0);
   endtask

   // Park in IDLE with a quiet input, then enable with the wave at phase 0
   task automatic start_wave(input int f, input int h);
      on_off   = 1'b0;
      gen_mode = 0;
      repeat (8) @(negedge in_clk);
      chk("idle_period", period_count, 0);
      chk("idle_no_signal", no_signal, 0);
      gen_f     = f;
      gen_h     = h;
      gen_phase = 0;
      rise_cnt  = 0;
      on_off    = 1'b1;
      gen_mode  = 1;
   endtask

   // With on_off low and wave running, enable just after a settled rise so
   // exactly two fresh rises precede the first valid
   task automatic restore_measure(input string tag);
      int cyc;
      bit ok;
      wait_meas_rise(40);
      repeat (4) @(negedge in_clk);
      rise_cnt = 0;
      on_off   = 1'b1;
      wait_valid(60, cyc, ok);
      chk({tag, "_valid_seen"}, ok, 1);
      chk({tag, "_fresh_edges"}, rise_cnt, 2);
      chk({tag, "_period"}, period_count, 10);
      chk({tag, "_high"}, high_count, hx(5));
      $display("%s recovery: period=%0d high=%0d after %0d fresh rises",
               tag, period_count, high_count, rise_cnt);
   endtask

   typedef struct {
      int f;
      int h;
      int exp_period;
      int exp_high;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int  cyc;
      bit  ok;
      int  tcount;
      int  nvalid;

      vecs[0] = '{f: 4,    h: 2,   exp_period: 4,    exp_high: hx(2)};
      vecs[1] = '{f: 2,    h: 1,   exp_period: 2,    exp_high: hx(1)};
      vecs[2] = '{f: 5,    h: 1,   exp_period: 5,    exp_high: hx(1)};
      vecs[3] = '{f: 7,    h: 4,   exp_period: 7,    exp_high: hx(4)};
      vecs[4] = '{f: 10,   h: 9,   exp_period: 10,   exp_high: hx(9)};
      vecs[5] = '{f: 1000, h: 500, exp_period: 1000, exp_high: hx(500)};

      // Reset state
      repeat (3) @(negedge in_clk);
      check_zero("reset");
      reset_n = 1'b1;
      @(negedge in_clk);

      // Table of waves: first valid after the 2nd rise, then steady results
      for (int i = 0; i < 6; i++) begin
         start_wave(vecs[i].f, vecs[i].h);
         wait_valid(4 * vecs[i].f + 20, cyc, ok);
         chk("first_valid_seen", ok, 1);
         chk("first_valid_after_2nd_rise", (rise_cnt >= 2), 1);
         chk("first_period", period_count, vecs[i].exp_period);
         chk("first_high", high_count, vecs[i].exp_high);
         for (int k = 0; k < 3; k++) begin
            wait_valid(vecs[i].f + 5, cyc, ok);
            chk("valid_seen", ok, 1);
            chk("valid_interval", cyc, vecs[i].f);
            chk("period", period_count, vecs[i].exp_period);
            chk("high", high_count, vecs[i].exp_high);
         end
         $display("wave F=%0d H=%0d: period=%0d high=%0d", vecs[i].f, vecs[i].h,
                  period_count, high_count);
      end

      // Timeout: input stuck low right after a measured edge
      start_wave(10, 5);
      wait_valid(60, cyc, ok);
      wait_valid(15, cyc, ok);
      chk("pre_timeout_valid", ok, 1);
      gen_mode = 0;
      tcount   = 0;
      nvalid   = 0;
      while (!no_signal && tcount < MAXC + 20) begin
         @(negedge in_clk);
         tcount++;
         if (valid) nvalid++;
      end
      chk("timeout_cycles", tcount, MAXC);
      chk("timeout_no_valid", nvalid, 0);
      chk("timeout_hold_period", period_count, 10);
      chk("timeout_hold_high", high_count, hx(5));
      $display("timeout: no_signal after %0d cycles, period held at %0d", tcount, period_count);
      gen_phase = 0;
      rise_cnt  = 0;
      gen_mode  = 1;
      cyc = 0;
      while (no_signal && cyc < 30) begin
         @(negedge in_clk);
         cyc++;
      end
      chk("no_signal_cleared", no_signal, 0);
      chk("rearm_no_valid", valid, 0);
      chk("rearm_rise_count", rise_cnt, 1);
      wait_valid(30, cyc, ok);
      chk("rearm_valid_seen", ok, 1);
      chk("rearm_rise_count_valid", rise_cnt, 2);
      chk("rearm_period", period_count, 10);
      $display("timeout recovery: no_signal=%0d period=%0d", no_signal, period_count);

      // on_off drop mid-period
      wait_valid(15, cyc, ok);
      repeat (4) @(negedge in_clk);
      on_off = 1'b0;
      @(negedge in_clk);
      check_zero("onoff_drop");
      nvalid = 0;
      repeat (20) begin
         @(negedge in_clk);
         if (valid) nvalid++;
      end
      chk("onoff_idle_no_valid", nvalid, 0);
      restore_measure("onoff");

      // Asynchronous reset between clock edges
      wait_valid(15, cyc, ok);
      repeat (3) @(negedge in_clk);
      #2;
      reset_n = 1'b0;
      on_off  = 1'b0;
      #1;
      check_zero("async_reset");
      @(negedge in_clk);
      reset_n = 1'b1;
      restore_measure("reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard stop so the run can never hang
   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "global timeout");
   end

endmodule
